// File: rtl/braille_letter_picker.sv
// Letter picker for the Braille trainer: samples the random generator on request,
// reduces the low byte mod 26, avoids immediate repeats and outputs letter + cell.
module braille_letter_picker (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rnd,
  input  logic        req,
  output logic        lfsr_run,
  output logic        busy,
  output logic        valid,
  output logic [4:0]  letter,
  output logic [5:0]  dots
);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    CHECK
  } state_t;

  localparam logic [4:0] PREV_NONE = 5'd31;

  state_t      state_q;
  logic [7:0]  r_q;
  logic [4:0]  prev_q;
  logic [4:0]  letter_q;
  logic [5:0]  dots_q;
  logic        valid_q;
  logic        busy_q;
  logic        run_q;

  logic [4:0]  pick_d;
  logic [5:0]  cell_d;

  // Only the low byte of the generator feeds the reduction.
  logic        unused_rnd;
  assign unused_rnd = ^rnd[15:8];

  // Grade-1 English Braille, bit0 = dot1 ... bit5 = dot6.
  function automatic logic [5:0] brailleCell(input logic [4:0] n);
    logic [5:0] c;
    case (n)
      5'd0:    c = 6'b000001;
      5'd1:    c = 6'b000011;
      5'd2:    c = 6'b001001;
      5'd3:    c = 6'b011001;
      5'd4:    c = 6'b010001;
      5'd5:    c = 6'b001011;
      5'd6:    c = 6'b011011;
      5'd7:    c = 6'b010011;
      5'd8:    c = 6'b001010;
      5'd9:    c = 6'b011010;
      5'd10:   c = 6'b000101;
      5'd11:   c = 6'b000111;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b011101;
      5'd14:   c = 6'b010101;
      5'd15:   c = 6'b001111;
      5'd16:   c = 6'b011111;
      5'd17:   c = 6'b010111;
      5'd18:   c = 6'b001110;
      5'd19:   c = 6'b011110;
      5'd20:   c = 6'b100101;
      5'd21:   c = 6'b100111;
      5'd22:   c = 6'b111010;
      5'd23:   c = 6'b101101;
      5'd24:   c = 6'b111101;
      5'd25:   c = 6'b110101;
      default: c = 6'b000000;
    endcase
    return c;
  endfunction

  // In CHECK r is already below 26; bump by one (wrapping z->a) on a repeat.
  always_comb begin
    pick_d = r_q[4:0];
    if (r_q[4:0] == prev_q) begin
      pick_d = (r_q[4:0] == 5'd25) ? 5'd0 : r_q[4:0] + 5'd1;
    end
    cell_d = brailleCell(pick_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      r_q      <= 8'd0;
      prev_q   <= PREV_NONE;
      letter_q <= 5'd0;
      dots_q   <= 6'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            r_q     <= rnd[7:0];
            busy_q  <= 1'b1;
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          if (r_q >= 8'd26) begin
            r_q <= r_q - 8'd26;
          end else begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          letter_q <= pick_d;
          dots_q   <= cell_d;
          prev_q   <= pick_d;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lfsr_run = run_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign letter   = letter_q;
  assign dots     = dots_q;

endmodule

// File: tb/tb_braille_letter_picker.sv
// Directed bench for braille_letter_picker: latency, letter/cell values,
// repeat avoidance, continuous requests and reset mid-pick.
module tb_braille_letter_picker;

  logic        clk;
  logic        rst;
  logic [15:0] rnd;
  logic        req;
  logic        lfsr_run;
  logic        busy;
  logic        valid;
  logic [4:0]  letter;
  logic [5:0]  dots;

  int checkCount = 0;
  int failCount  = 0;

  braille_letter_picker dut (
    .clk      (clk),
    .rst      (rst),
    .rnd      (rnd),
    .req      (req),
    .lfsr_run (lfsr_run),
    .busy     (busy),
    .valid    (valid),
    .letter   (letter),
    .dots     (dots)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One pick: pulse req with byte v, then time valid and busy against the expectation.
  task automatic applyStimulus(input string tag, input logic [7:0] v, input logic [4:0] expLetter,
                               input logic [5:0] expDots, input int expLat);
    int lat;
    int busyCycles;
    bit seen;
    rnd = {8'hC3, v};
    req = 1'b1;
    tick();
    req = 1'b0;
    lat = 0;
    busyCycles = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy) busyCycles++;
      tick();
      lat++;
      if (valid) seen = 1;
    end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_busyCycles"}, busyCycles, expLat);
    checkOutput({tag, "_busyLowAtValid"}, busy, 1'b0);
    checkOutput({tag, "_letter"}, letter, expLetter);
    checkOutput({tag, "_dots"}, dots, expDots);
    tick();
    checkOutput({tag, "_validOneCycle"}, valid, 1'b0);
    checkOutput({tag, "_letterHold"}, letter, expLetter);
  endtask

  logic [7:0] contRnd [12];
  bit         contValid [12];
  int         validSeen;

  initial begin
    rst = 1'b0;
    rnd = 16'h0000;
    req = 1'b0;
    tick();
    tick();
    checkOutput("reset_run", lfsr_run, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_valid", valid, 1'b0);
    checkOutput("reset_letter", letter, 5'd0);
    checkOutput("reset_dots", dots, 6'd0);

    rst = 1'b1;
    tick();
    checkOutput("run_after_first_edge", lfsr_run, 1'b1);
    tick();
    tick();
    checkOutput("idle_run", lfsr_run, 1'b1);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_valid", valid, 1'b0);
    checkOutput("idle_letter", letter, 5'd0);

    rnd = 16'hFF00;
    applyStimulus("v00", 8'h00, 5'd0, 6'b000001, 2);
    applyStimulus("vFF", 8'hFF, 5'd21, 6'b100111, 11);
    applyStimulus("v1A", 8'h1A, 5'd0, 6'b000001, 3);
    applyStimulus("repeat_v00", 8'h00, 5'd1, 6'b000011, 2);
    applyStimulus("v19", 8'h19, 5'd25, 6'b110101, 2);
    applyStimulus("wrap_v33", 8'h33, 5'd0, 6'b000001, 3);
    applyStimulus("v0A", 8'h0A, 5'd10, 6'b000101, 2);
    applyStimulus("v02", 8'h02, 5'd2, 6'b001001, 2);

    // Continuous req: picks start at edges 0, 3 and 7; other bytes must be ignored.
    contRnd = '{8'h05, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00,
                8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    contValid = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int c = 0; c < 12; c++) begin
      rnd = {8'h99, contRnd[c]};
      req = 1'b1;
      tick();
      checkOutput($sformatf("cont_valid_%0d", c), valid, contValid[c]);
      if (c == 2) begin
        checkOutput("cont_letter_f", letter, 5'd5);
        checkOutput("cont_dots_f", dots, 6'b001011);
      end
      if (c == 6) begin
        checkOutput("cont_letter_g", letter, 5'd6);
        checkOutput("cont_dots_g", dots, 6'b011011);
      end
      if (c == 11) begin
        checkOutput("cont_letter_m", letter, 5'd12);
        checkOutput("cont_dots_m", dots, 6'b001101);
      end
    end
    req = 1'b0;
    tick();
    checkOutput("cont_end_valid", valid, 1'b0);
    tick();

    applyStimulus("pre_abort_v00", 8'h00, 5'd0, 6'b000001, 2);

    // Abort a long pick with reset four edges into it.
    rnd = 16'h00FF;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_run", lfsr_run, 1'b0);
    rst = 1'b1;
    validSeen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (valid) validSeen++;
    end
    checkOutput("abort_no_valid", validSeen, 0);
    checkOutput("abort_letter", letter, 5'd0);
    checkOutput("abort_dots", dots, 6'd0);
    checkOutput("abort_busy", busy, 1'b0);
    applyStimulus("after_abort_v00", 8'h00, 5'd0, 6'b000001, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
